mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU's memory request interface.
- Services instruction-fetch and data read/write requests from the control/datapath side against an internal word-addressed RAM.
- Inserts a programmable number of wait states, then signals completion with a one-cycle ready pulse.
- Flags misaligned or out-of-range addresses, and provides a registered debug read port for the debug unit.

Parameters:
- WIDTH, 32, data and address width in bits.
- DEPTH_W, 8, log2 of RAM depth in words (256 words).
- LATENCY, 2, wait cycles between request acceptance and access; legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_read  in  1  read request; held by the requester until ready.
- req_write  in  1  write request; held by the requester until ready.
- addr  in  WIDTH  byte address of the request.
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  read data; valid in the cycle ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  valid with ready; 1 means the request was rejected and no access occurred.
- busy  out  1  high from acceptance through the RESP cycle.
- dbg_addr  in  DEPTH_W  debug word address.
- dbg_data  out  WIDTH  RAM[dbg_addr], registered, updated every cycle.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, ready=0, err=0, busy=0, rdata=0, dbg_data=0, wait counter=0.
  - RAM contents are not cleared.
  - A reset mid-WAIT aborts the access with no RAM write.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req_read or req_write is 1, latch addr, wdata and op, and set cnt=LATENCY.
  - If LATENCY=0, go to RESP; otherwise go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - cnt decrements by 1 each cycle.
  - When cnt=1, the access is performed on that edge and the state goes to RESP.
  - Request inputs are ignored while in WAIT.
- RESP:
  - ready=1 for exactly one cycle, then return to IDLE.
  - A request still asserted in the cycle after RESP is accepted as a new request. The requester must deassert within the RESP cycle to avoid a repeat.
- Latency: request first sampled at edge N, ready=1 during cycle N+LATENCY+1.
- Access performed on the edge entering RESP:
  - Read: rdata <= RAM[addr[DEPTH_W+1:2]].
  - Write: RAM[...] <= wdata; rdata unchanged.
- Error checks on the latched request (err=1, no RAM access, rdata unchanged):
  - addr[1:0] != 0 (misaligned).
  - addr[WIDTH-1:DEPTH_W+2] != 0 (out of range).
  - req_read and req_write both 1 at acceptance (conflict).
  - err stays 0 whenever ready=0.
- Debug port:
  - dbg_data <= RAM[dbg_addr] every edge, independent of state.
  - When a write and a debug read hit the same word on the same edge, dbg_data returns the old value; the new value appears one cycle later.
- Ordering: a write completes before its ready pulse, so a read issued after that ready returns the new data.
- Wait counter is 4 bits; LATENCY outside 0..15 is a parameter error and is caught by a simulation-only check.

Test Plan:
- LATENCY=2: write addr=0x10, wdata=0xDEADBEEF.
  - ready=1, err=0 exactly 3 cycles after acceptance.
  - Then a read of 0x10 returns rdata=0xDEADBEEF with ready 3 cycles after acceptance.
- LATENCY=0: back-to-back reads of 0x0 and 0x4, with requests held high.
  - ready pulses on alternating cycles.
  - rdata matches the preloaded words 0x11111111 and 0x22222222.
- Read addr=0x6 (misaligned) and read addr=0x400 (out of range, DEPTH_W=8).
  - Each gives ready=1 with err=1; rdata holds its previous value.
- req_read=1 and req_write=1 together at addr=0x8 holding 0x55.
  - Gives ready=1 with err=1; RAM[2] stays 0x55 as seen on dbg_data.
- Write 0xCAFEF00D to word 5 with dbg_addr=5.
  - dbg_data shows the old value on the write edge and 0xCAFEF00D one cycle later.
- Assert rst=0 mid-WAIT during a write to 0x20 holding 0x0.
  - ready, err and busy drop to 0 immediately.
  - RAM[8] is still 0x0 after reset release, and the next request is serviced normally.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU's memory controller (master)
// and the memory responder (slave).
interface mem_responder_if #(
  parameter int WIDTH = 32
);
  logic             req_read;
  logic             req_write;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             ready;
  logic             err;
  logic             busy;

  modport master (
    output req_read, req_write, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req_read, req_write, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM responder with programmable wait states, request
// validation and a registered debug read port.
module mem_responder #(
  parameter int WIDTH   = 32,
  parameter int DEPTH_W = 8,
  parameter int LATENCY = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  mem_responder_if.slave      bus,
  input  logic [DEPTH_W-1:0]  dbg_addr_i,
  output logic [WIDTH-1:0]    dbg_data_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [3:0] LatCnt  = 4'(LATENCY);
  localparam bit         ZeroLat = (LATENCY == 0);

  if (LATENCY < 0 || LATENCY > 15) begin : gBadLatency
    $error("mem_responder: LATENCY must lie within 0..15");
  end

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   addr_q, wdata_q, rdata_q, dbgData_q;
  logic               rd_q, wr_q, err_q;
  logic [WIDTH-1:0]   mem [0:(1<<DEPTH_W)-1];

  logic               anyReq, accept, access;
  logic               accRd, accWr, accErr;
  logic [WIDTH-1:0]   accAddr, accWdata;
  logic [DEPTH_W-1:0] accIdx;

  // With zero latency the access happens on the acceptance edge, so it
  // must use the live request rather than the latched copy.
  always_comb begin
    anyReq = bus.req_read | bus.req_write;
    accept = (state_q == IDLE) && anyReq;
    if (state_q == IDLE) begin
      accRd    = bus.req_read;
      accWr    = bus.req_write;
      accAddr  = bus.addr;
      accWdata = bus.wdata;
    end else begin
      accRd    = rd_q;
      accWr    = wr_q;
      accAddr  = addr_q;
      accWdata = wdata_q;
    end
    access = (accept && ZeroLat) || ((state_q == WAIT) && (cnt_q == 4'd1));
    accErr = (accAddr[1:0] != 2'b00) ||
             (accAddr[WIDTH-1:DEPTH_W+2] != '0) ||
             (accRd && accWr);
    accIdx = accAddr[DEPTH_W+1:2];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          cnt_d   = LatCnt;
          state_d = ZeroLat ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state_q == RESP);
    bus.err   = (state_q == RESP) && err_q;
    bus.busy  = (state_q != IDLE);
    bus.rdata = rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      dbgData_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        rd_q    <= bus.req_read;
        wr_q    <= bus.req_write;
      end
      if (access) begin
        err_q <= accErr;
        if (accRd && !accWr && !accErr) rdata_q <= mem[accIdx];
      end
      dbgData_q <= mem[dbg_addr_i];
    end
  end

  // RAM is never cleared; a reset simply prevents the pending access.
  always_ff @(posedge clk_i) begin
    if (access && accWr && !accErr) mem[accIdx] <= accWdata;
  end

  assign dbg_data_o = dbgData_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one responder with LATENCY=2 and one with LATENCY=0.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  dbgAddr2, dbgAddr0;
  logic [31:0] dbgData2, dbgData0;
  int          checks;
  int          failures;

  mem_responder_if #(.WIDTH(32)) bus2 ();
  mem_responder_if #(.WIDTH(32)) bus0 ();

  mem_responder #(.WIDTH(32), .DEPTH_W(8), .LATENCY(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus2),
    .dbg_addr_i(dbgAddr2), .dbg_data_o(dbgData2)
  );

  mem_responder #(.WIDTH(32), .DEPTH_W(8), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0),
    .dbg_addr_i(dbgAddr0), .dbg_data_o(dbgData0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one request, count edges until ready and capture the response.
  task automatic doReq(input bit sel0, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rdat,
                       output logic e, output logic [31:0] dbg);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(sel0 ? bus0.busy : bus2.busy)) break;
    end
    if (sel0) begin
      bus0.req_read = rd; bus0.req_write = wr; bus0.addr = a; bus0.wdata = wd;
    end else begin
      bus2.req_read = rd; bus2.req_write = wr; bus2.addr = a; bus2.wdata = wd;
    end
    lat  = 0;
    rdat = 'x;
    e    = 1'bx;
    dbg  = 'x;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (sel0 ? bus0.ready : bus2.ready) begin
        rdat = sel0 ? bus0.rdata : bus2.rdata;
        e    = sel0 ? bus0.err : bus2.err;
        dbg  = sel0 ? dbgData0 : dbgData2;
        break;
      end
    end
    if (sel0) begin
      bus0.req_read = 1'b0; bus0.req_write = 1'b0;
    end else begin
      bus2.req_read = 1'b0; bus2.req_write = 1'b0;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bus2.ready, bus2.err, bus2.busy} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {bus2.ready, bus2.err, bus2.busy});
    end
    checks++;
    if (bus2.rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_rdata: got %h expected 00000000", bus2.rdata);
    end
    checks++;
    if (dbgData2 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_dbg: got %h expected 00000000", dbgData2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd, dbg; logic e;
    doReq(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e, dbg);
    checks++;
    if (lat !== 3 || e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_latency: got lat=%0d err=%b expected lat=3 err=0", lat, e);
    end
    doReq(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rd, e, dbg);
    checks++;
    if (lat !== 3 || e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL read_latency: got lat=%0d err=%b expected lat=3 err=0", lat, e);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL read_data: got %h expected deadbeef", rd);
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd, dbg; logic e;
    logic [31:0] badAddr [2];
    badAddr[0] = 32'h6;
    badAddr[1] = 32'h400;
    for (int i = 0; i < 2; i++) begin
      doReq(1'b0, 1'b1, 1'b0, badAddr[i], 32'h0, lat, rd, e, dbg);
      checks++;
      if (lat !== 3 || e !== 1'b1) begin
        failures++;
        $display("[TB] FAIL bad_addr_err %h: got lat=%0d err=%b expected lat=3 err=1", badAddr[i], lat, e);
      end
      checks++;
      if (rd !== 32'hDEADBEEF) begin
        failures++;
        $display("[TB] FAIL bad_addr_rdata %h: got %h expected deadbeef", badAddr[i], rd);
      end
    end
  endtask

  task automatic test_conflict();
    int lat; logic [31:0] rd, dbg; logic e;
    doReq(1'b0, 1'b0, 1'b1, 32'h8, 32'h55, lat, rd, e, dbg);
    doReq(1'b0, 1'b1, 1'b1, 32'h8, 32'h99, lat, rd, e, dbg);
    checks++;
    if (lat !== 3 || e !== 1'b1) begin
      failures++;
      $display("[TB] FAIL conflict_err: got lat=%0d err=%b expected lat=3 err=1", lat, e);
    end
    @(negedge clk);
    dbgAddr2 = 8'd2;
    @(posedge clk);
    #1;
    checks++;
    if (dbgData2 !== 32'h55) begin
      failures++;
      $display("[TB] FAIL conflict_ram: got %h expected 00000055", dbgData2);
    end
  endtask

  task automatic test_debug_bypass();
    int lat; logic [31:0] rd, dbg; logic e;
    doReq(1'b0, 1'b0, 1'b1, 32'h14, 32'h12345678, lat, rd, e, dbg);
    dbgAddr2 = 8'd5;
    doReq(1'b0, 1'b0, 1'b1, 32'h14, 32'hCAFEF00D, lat, rd, e, dbg);
    checks++;
    if (dbg !== 32'h12345678) begin
      failures++;
      $display("[TB] FAIL dbg_old: got %h expected 12345678", dbg);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dbgData2 !== 32'hCAFEF00D) begin
      failures++;
      $display("[TB] FAIL dbg_new: got %h expected cafef00d", dbgData2);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd, dbg; logic e;
    logic [3:0] readyPat;
    logic [31:0] rdA, rdB;
    doReq(1'b1, 1'b0, 1'b1, 32'h0, 32'h11111111, lat, rd, e, dbg);
    checks++;
    if (lat !== 1 || e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lat0_write: got lat=%0d err=%b expected lat=1 err=0", lat, e);
    end
    doReq(1'b1, 1'b0, 1'b1, 32'h4, 32'h22222222, lat, rd, e, dbg);
    @(negedge clk);
    @(negedge clk);
    bus0.req_read = 1'b1;
    bus0.addr     = 32'h0;
    rdA = 'x;
    rdB = 'x;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      readyPat[3-i] = bus0.ready;
      if (i == 0) begin
        rdA = bus0.rdata;
        bus0.addr = 32'h4;
      end
      if (i == 2) begin
        rdB = bus0.rdata;
        bus0.req_read = 1'b0;
      end
    end
    checks++;
    if (readyPat !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL b2b_ready: got %b expected 1010", readyPat);
    end
    checks++;
    if (rdA !== 32'h11111111 || rdB !== 32'h22222222) begin
      failures++;
      $display("[TB] FAIL b2b_rdata: got %h %h expected 11111111 22222222", rdA, rdB);
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [31:0] rd, dbg; logic e;
    doReq(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, lat, rd, e, dbg);
    @(negedge clk);
    @(negedge clk);
    bus2.req_write = 1'b1;
    bus2.addr      = 32'h20;
    bus2.wdata     = 32'h00000BAD;
    @(posedge clk);
    #1;
    checks++;
    if (bus2.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_accept: got %b expected 1", bus2.busy);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus2.ready, bus2.err, bus2.busy} !== 3'b000 || bus2.rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL abort_flags: got %b rdata=%h expected 000 rdata=00000000",
               {bus2.ready, bus2.err, bus2.busy}, bus2.rdata);
    end
    bus2.req_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dbgAddr2 = 8'd8;
    @(posedge clk);
    #1;
    checks++;
    if (dbgData2 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL abort_ram: got %h expected 00000000", dbgData2);
    end
    doReq(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rd, e, dbg);
    checks++;
    if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL post_reset_read: got lat=%0d err=%b rdata=%h expected lat=3 err=0 rdata=deadbeef",
               lat, e, rd);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    dbgAddr2 = 8'd0;
    dbgAddr0 = 8'd0;
    bus2.req_read = 1'b0; bus2.req_write = 1'b0; bus2.addr = '0; bus2.wdata = '0;
    bus0.req_read = 1'b0; bus0.req_write = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    test_reset();
    test_write_read();
    test_errors();
    test_conflict();
    test_debug_bypass();
    test_back_to_back();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
